// File: rtl/line_alloc_ctrl.sv
// Occupancy tracker and clear sequencer for the 128-entry line array behind the 7-to-128 decoder.
// Optional build macro: LINE_ALLOC_RR_EN selects round-robin free-entry search instead of lowest-index-first.
module line_alloc_ctrl #(
    parameter int IDX_W   = 7,
    parameter int ENTRIES = 128
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               alloc_req,
    output logic               alloc_gnt,
    output logic [IDX_W-1:0]   alloc_idx,
    input  logic               free_req,
    input  logic [IDX_W-1:0]   free_idx,
    input  logic               flush_req,
    output logic               wr_en,
    output logic [IDX_W-1:0]   wr_idx,
    output logic               busy,
    output logic               full,
    output logic [IDX_W:0]     count,
    output logic [ENTRIES-1:0] valid_vec
);

    typedef enum logic {CLEAR, IDLE} state_t;

    localparam logic [IDX_W:0] FULL_CNT = ENTRIES[IDX_W:0];

    state_t             state_reg, state_next;
    logic [IDX_W-1:0]   clr_ptr_reg, clr_ptr_next;
    logic [ENTRIES-1:0] valid_vec_reg, valid_vec_next;
    logic [IDX_W:0]     count_reg, count_next;
`ifdef LINE_ALLOC_RR_EN
    logic [IDX_W-1:0]   rr_ptr_reg, rr_ptr_next;
`endif

    logic               found;
    logic [IDX_W-1:0]   cand_idx;
    logic [IDX_W-1:0]   probe_idx;
    logic               idle;
    logic               grant;
    logic               free_hit;
    logic [ENTRIES-1:0] valid_upd;

    // Scan from the highest offset down so the last hit is the lowest offset from the search base.
    always_comb begin
        found     = 1'b0;
        cand_idx  = '0;
        probe_idx = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
`ifdef LINE_ALLOC_RR_EN
            probe_idx = rr_ptr_reg + i[IDX_W-1:0];
`else
            probe_idx = i[IDX_W-1:0];
`endif
            if (!valid_vec_reg[probe_idx]) begin
                found    = 1'b1;
                cand_idx = probe_idx;
            end
        end
    end

    assign idle     = (state_reg == IDLE);
    assign full     = (count_reg == FULL_CNT);
    assign grant    = idle & alloc_req & ~full & ~flush_req & found;
    assign free_hit = idle & ~flush_req & free_req & valid_vec_reg[free_idx];

    // A granted entry is always free pre-edge and a hit free is always occupied, so set and clear never collide.
    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_valid
            assign valid_upd[gi] = (valid_vec_reg[gi] & ~(free_hit && (free_idx == IDX_W'(gi))))
                                 | (grant && (cand_idx == IDX_W'(gi)));
        end
    endgenerate

    always_comb begin
        state_next     = state_reg;
        clr_ptr_next   = clr_ptr_reg;
        valid_vec_next = valid_vec_reg;
        count_next     = count_reg;
`ifdef LINE_ALLOC_RR_EN
        rr_ptr_next    = rr_ptr_reg;
`endif
        wr_en          = 1'b0;
        wr_idx         = '0;
        alloc_gnt      = 1'b0;
        alloc_idx      = cand_idx;
        case (state_reg)
            CLEAR: begin
                wr_en  = 1'b1;
                wr_idx = clr_ptr_reg;
                if (clr_ptr_reg == {IDX_W{1'b1}}) begin
                    state_next   = IDLE;
                    clr_ptr_next = '0;
                end else begin
                    clr_ptr_next = clr_ptr_reg + 1'b1;
                end
            end
            IDLE: begin
                if (flush_req) begin
                    state_next     = CLEAR;
                    clr_ptr_next   = '0;
                    valid_vec_next = '0;
                    count_next     = '0;
`ifdef LINE_ALLOC_RR_EN
                    rr_ptr_next    = '0;
`endif
                end else begin
                    alloc_gnt      = grant;
                    wr_en          = grant;
                    wr_idx         = grant ? cand_idx : '0;
                    valid_vec_next = valid_upd;
                    count_next     = count_reg + {{IDX_W{1'b0}}, grant} - {{IDX_W{1'b0}}, free_hit};
`ifdef LINE_ALLOC_RR_EN
                    if (grant) begin
                        rr_ptr_next = cand_idx + 1'b1;
                    end
`endif
                end
            end
            default: begin
                state_next = CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= CLEAR;
            clr_ptr_reg   <= '0;
            valid_vec_reg <= '0;
            count_reg     <= '0;
`ifdef LINE_ALLOC_RR_EN
            rr_ptr_reg    <= '0;
`endif
        end else begin
            state_reg     <= state_next;
            clr_ptr_reg   <= clr_ptr_next;
            valid_vec_reg <= valid_vec_next;
            count_reg     <= count_next;
`ifdef LINE_ALLOC_RR_EN
            rr_ptr_reg    <= rr_ptr_next;
`endif
        end
    end

    assign busy      = (state_reg == CLEAR);
    assign count     = count_reg;
    assign valid_vec = valid_vec_reg;

endmodule

// File: tb/tb_line_alloc_ctrl.sv
// Scoreboard bench for line_alloc_ctrl: a reference occupancy model queues expected outputs per cycle.
module tb_line_alloc_ctrl;

    logic         clk;
    logic         rst_n;
    logic         alloc_req;
    logic         alloc_gnt;
    logic [6:0]   alloc_idx;
    logic         free_req;
    logic [6:0]   free_idx;
    logic         flush_req;
    logic         wr_en;
    logic [6:0]   wr_idx;
    logic         busy;
    logic         full;
    logic [7:0]   count;
    logic [127:0] valid_vec;

    line_alloc_ctrl #(.IDX_W(7), .ENTRIES(128)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .alloc_req (alloc_req),
        .alloc_gnt (alloc_gnt),
        .alloc_idx (alloc_idx),
        .free_req  (free_req),
        .free_idx  (free_idx),
        .flush_req (flush_req),
        .wr_en     (wr_en),
        .wr_idx    (wr_idx),
        .busy      (busy),
        .full      (full),
        .count     (count),
        .valid_vec (valid_vec)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef LINE_ALLOC_RR_EN
    localparam int REALLOC_EXP = 3;
`else
    localparam int REALLOC_EXP = 1;
`endif

    typedef struct {
        logic         gnt;
        logic [6:0]   idx;
        logic         wr_en;
        logic [6:0]   wr_idx;
        logic         busy;
        logic [7:0]   count;
        logic [127:0] valid;
        logic         full;
    } exp_t;

    exp_t exp_q[$];

    int n_checks;
    int n_errors;

    // reference model state
    logic [127:0] m_valid;
    int           m_count;
    int           m_state;   // 0 = sweeping, 1 = idle
    int           m_ptr;
    int           m_rr;

    logic         last_gnt;
    logic [6:0]   last_idx;
    logic         last_wr;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int find_free();
        int j;
        for (int k = 0; k < 128; k++) begin
`ifdef LINE_ALLOC_RR_EN
            j = (m_rr + k) % 128;
`else
            j = k;
`endif
            if (!m_valid[j]) return j;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_valid = '0;
        m_count = 0;
        m_state = 0;
        m_ptr   = 0;
        m_rr    = 0;
        exp_q.delete();
    endtask

    // One clock: drive at negedge, sample combinational outputs, push model prediction, compare after the edge.
    task automatic cycle(input logic a, input logic f, input logic [6:0] fi, input logic fl);
        exp_t       e;
        logic       o_gnt, o_wr, o_busy;
        logic [6:0] o_idx, o_wri;
        int         c;
        @(negedge clk);
        alloc_req = a;
        free_req  = f;
        free_idx  = fi;
        flush_req = fl;
        #1;
        o_gnt  = alloc_gnt;
        o_idx  = alloc_idx;
        o_wr   = wr_en;
        o_wri  = wr_idx;
        o_busy = busy;
        e.busy   = (m_state == 0);
        e.gnt    = 1'b0;
        e.idx    = '0;
        e.wr_en  = 1'b0;
        e.wr_idx = '0;
        if (m_state == 0) begin
            e.wr_en  = 1'b1;
            e.wr_idx = 7'(m_ptr);
            if (m_ptr == 127) begin
                m_state = 1;
                m_ptr   = 0;
            end else begin
                m_ptr++;
            end
        end else if (fl) begin
            m_valid = '0;
            m_count = 0;
            m_state = 0;
            m_ptr   = 0;
            m_rr    = 0;
        end else begin
            c = find_free();
            if (a && m_count < 128 && c >= 0) begin
                e.gnt    = 1'b1;
                e.idx    = 7'(c);
                e.wr_en  = 1'b1;
                e.wr_idx = 7'(c);
            end
            if (f && m_valid[fi]) begin
                m_valid[fi] = 1'b0;
                m_count--;
            end
            if (e.gnt) begin
                m_valid[c] = 1'b1;
                m_count++;
                m_rr = (c + 1) % 128;
            end
        end
        e.count = 8'(m_count);
        e.valid = m_valid;
        e.full  = (m_count == 128);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        chk("alloc_gnt", o_gnt, e.gnt);
        if (e.gnt) chk("alloc_idx", o_idx, e.idx);
        chk("wr_en", o_wr, e.wr_en);
        chk("wr_idx", o_wri, e.wr_idx);
        chk("busy", o_busy, e.busy);
        chk("count", count, e.count);
        chk("valid_vec", valid_vec, e.valid);
        chk("full", full, e.full);
        last_gnt = o_gnt;
        last_idx = o_idx;
        last_wr  = o_wr;
        if (a | f | fl)
            $display("txn t=%0t alloc=%0b free=%0b/%0d flush=%0b -> gnt=%0b idx=%0d wr_en=%0b count=%0d",
                     $time, a, f, fi, fl, o_gnt, o_idx, o_wr, count);
    endtask

    task automatic reset_values(input string tag);
        chk({tag, "_busy"}, busy, 1'b1);
        chk({tag, "_wr_en"}, wr_en, 1'b1);
        chk({tag, "_wr_idx"}, wr_idx, 7'd0);
        chk({tag, "_gnt"}, alloc_gnt, 1'b0);
        chk({tag, "_full"}, full, 1'b0);
        chk({tag, "_count"}, count, 8'd0);
        chk({tag, "_valid"}, valid_vec, 128'd0);
    endtask

    task automatic sweep(input logic a);
        for (int i = 0; i < 128; i++) begin
            cycle(a, 1'b0, 7'd0, 1'b0);
            if (i == 126) chk("sweep_busy_127", busy, 1'b1);
        end
        chk("sweep_done_busy", busy, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        alloc_req = 1'b1;
        free_req  = 1'b0;
        free_idx  = '0;
        flush_req = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset_values("rst");
        rst_n = 1'b1;

        // post-reset sweep with an ignored flush/free in the middle
        for (int i = 0; i < 128; i++) begin
            if (i == 10) cycle(1'b0, 1'b1, 7'd0, 1'b1);
            else         cycle(1'b0, 1'b0, 7'd0, 1'b0);
        end
        chk("boot_busy", busy, 1'b0);
        chk("boot_count", count, 8'd0);
        chk("boot_valid", valid_vec, 128'd0);

        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 7'd0, 1'b0);
            chk("b2b_idx", last_idx, 7'(k));
        end
        chk("b2b_count", count, 8'd3);
        cycle(1'b0, 1'b1, 7'd1, 1'b0);
        cycle(1'b1, 1'b0, 7'd0, 1'b0);
        chk("realloc_idx", last_idx, 7'(REALLOC_EXP));

        for (int k = 0; k < 200 && m_count < 128; k++) cycle(1'b1, 1'b0, 7'd0, 1'b0);
        chk("fill_full", full, 1'b1);
        chk("fill_count", count, 8'd128);
        cycle(1'b1, 1'b0, 7'd0, 1'b0);
        chk("full_nogrant", last_gnt, 1'b0);
        cycle(1'b1, 1'b1, 7'd5, 1'b0);
        chk("full_free_nogrant", last_gnt, 1'b0);
        chk("full_free_count", count, 8'd127);
        chk("full_free_bit5", valid_vec[5], 1'b0);
        cycle(1'b1, 1'b0, 7'd0, 1'b0);
        chk("refill_gnt", last_gnt, 1'b1);
        chk("refill_idx", last_idx, 7'd5);

        cycle(1'b0, 1'b1, 7'd40, 1'b0);
        cycle(1'b0, 1'b1, 7'd40, 1'b0);
        chk("free_nop_count", count, 8'd127);
        chk("free_nop_wr_en", last_wr, 1'b0);

        // flush, resweep, then flush again at count 10 alongside alloc and free
        cycle(1'b0, 1'b0, 7'd0, 1'b1);
        sweep(1'b0);
        repeat (10) cycle(1'b1, 1'b0, 7'd0, 1'b0);
        chk("pre_flush_count", count, 8'd10);
        cycle(1'b1, 1'b1, 7'd3, 1'b1);
        chk("flush_nogrant", last_gnt, 1'b0);
        chk("flush_count", count, 8'd0);
        chk("flush_busy", busy, 1'b1);
        for (int k = 0; k < 200 && m_ptr != 60; k++) cycle(1'b1, 1'b0, 7'd0, 1'b0);
        chk("pre_rst_wr_idx", wr_idx, 7'd60);

        // asynchronous reset mid-sweep
        #1;
        rst_n = 1'b0;
        #1;
        reset_values("midrst");
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sweep(1'b1);

        // random traffic with rare flushes
        for (int k = 0; k < 300; k++) begin
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                  7'($urandom_range(0, 15)), 1'($urandom_range(0, 149) == 0));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/line_alloc_ctrl.md
# line_alloc_ctrl

Allocation and clear controller for the 128-entry line array addressed through the shared 7-to-128 one-hot decoder. It tracks which entries are occupied, grants free entries to an allocating requester, and accepts releases. After reset or a flush it sequences a full clear sweep, driving the decoder one index per cycle. It sits between the fill/evict logic and the line array's write-enable path.

## Interface

- `IDX_W`, 7: index width; the decoder input width.
- `ENTRIES`, 128: entry count; must equal 2**IDX_W.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alloc_req`  in  1  request one free entry this cycle.
- `alloc_gnt`  out  1  combinational grant; the entry is taken at this edge.
- `alloc_idx`  out  IDX_W  granted index; valid only when `alloc_gnt`=1.
- `free_req`  in  1  release entry `free_idx`.
- `free_idx`  in  IDX_W  entry to release.
- `flush_req`  in  1  single-cycle pulse: invalidate all entries and re-sweep.
- `wr_en`  out  1  write strobe to the line array.
- `wr_idx`  out  IDX_W  decoder index input.
- `busy`  out  1  high in CLEAR.
- `full`  out  1  all entries occupied.
- `count`  out  IDX_W+1  number of occupied entries, 0..128.
- `valid_vec`  out  ENTRIES  occupancy map; bit i = entry i occupied.

## Operation

- FSM states: CLEAR and IDLE. Reset state is CLEAR, with `clr_ptr`=0, `valid_vec`=0, and `count`=0.
- CLEAR:
  - `wr_en`=1 and `wr_idx`=`clr_ptr`; `clr_ptr` increments each edge.
  - At the edge where `clr_ptr`=127, go to IDLE and reset `clr_ptr` to 0.
  - `alloc_gnt`=0. `free_req` and `flush_req` are ignored.
- IDLE, flush:
  - `flush_req`=1 takes priority over everything.
  - `alloc_gnt`=0 and any `free_req` is dropped.
  - Next edge: `valid_vec`=0, `count`=0, state goes to CLEAR.
- IDLE, alloc:
  - `alloc_gnt` = `alloc_req` & ~`full` & ~`flush_req`.
  - `alloc_idx` is the lowest index whose `valid_vec` bit is 0, searched from the pre-edge vector.
  - On grant: `wr_en`=1 and `wr_idx`=`alloc_idx`; that bit is set at the edge.
  - With no grant: `wr_en`=0 and `wr_idx`=0.
- IDLE, free:
  - If `valid_vec[free_idx]`=1, the bit is cleared at the edge.
  - Freeing an already-free entry is a no-op, and `count` is unchanged.
  - A free never asserts `wr_en`.
- Simultaneous alloc and free in the same cycle:
  - Both apply.
  - The freed index is not grantable in that cycle, because the search uses the pre-edge vector.
  - `count` is unchanged net.
- `count`:
  - +1 on a grant, -1 on a valid free, 0 net when both happen.
  - Saturation is impossible by construction.
- `full` = (`count` == ENTRIES). While `full`=1, a simultaneous free is still accepted and the alloc is not granted.

## Timing

- Reset values (while `rst_n`=0): `busy`=1, `wr_en`=1, `wr_idx`=0, `alloc_gnt`=0, `full`=0, `count`=0, `valid_vec`=0.
- The post-reset sweep occupies 128 cycles; `busy` falls on the 128th rising edge after `rst_n` deasserts.
- Flush latency: `busy`=1 from the edge after `flush_req`, lasting 128 cycles.
- Grant is zero-latency (combinational). `valid_vec`, `count` and `full` reflect the grant or free one edge later.
- Reset asserted mid-sweep or mid-operation immediately restores all reset values, and the sweep restarts at index 0.

## Configuration

- `LINE_ALLOC_RR_EN` defined:
  - Round-robin search: the candidate is the lowest free index at or above `rr_ptr`, wrapping 127 to 0.
  - `rr_ptr` is set to `alloc_idx`+1 (mod 128) on each grant.
  - `rr_ptr` resets to 0 on reset or flush.
- Undefined: fixed lowest-index-first search, and no `rr_ptr` register exists.

## Test plan

- Reset release: `wr_idx` steps 0,1,…,127 with `wr_en`=1 for 128 cycles, then `busy`=0, `count`=0, `valid_vec`=0.
- 3 back-to-back allocs after the sweep give `alloc_idx` 0,1,2 and `count`=3. Free 1, then alloc: default grants 1; with `LINE_ALLOC_RR_EN` it grants 3.
- Allocate all 128: `full`=1 and `count`=128. The next alloc gives `alloc_gnt`=0. Alloc+free(5) in the same cycle: no grant, entry 5 cleared, `count`=127. The next alloc grants 5.
- Free an already-free index 40: `valid_vec` and `count` unchanged, `wr_en`=0.
- `flush_req` with `alloc_req` in IDLE at `count`=10: no grant. Next cycle `count`=0 and `busy`=1, and the sweep runs 0..127. An `alloc_req` mid-sweep is never granted.
- Assert `rst_n`=0 mid-sweep at index 60: outputs return to reset values. After release the sweep restarts at 0 and still takes 128 cycles.
